// File: rtl/weight_bram_stream_reader.sv
// Streams DEPTH weight words out of a negedge-read BRAM onto a valid/ready port.
// A 2-entry output buffer absorbs consumer backpressure without losing words.
module weight_bram_stream_reader #(
   parameter int unsigned DEPTH  = 28,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 16
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              START,
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W-1:0] ADDR,
   output logic              EN,
   output logic              WE,
   input  logic [DATA_W-1:0] DI,
   output logic [DATA_W-1:0] OUT_DATA,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic              OUT_LAST,
   output logic [ADDR_W-1:0] OUT_IDX
);

   localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              en_q, en_d;
   logic [1:0]        count_q, count_d;
   logic [DATA_W-1:0] data0_q, data0_d, data1_q, data1_d;
   logic [ADDR_W-1:0] idx0_q, idx0_d, idx1_q, idx1_d;
   logic              last0_q, last0_d, last1_q, last1_d;
   logic              push, pop, push_last;

   // en_q doubles as the inflight flag: the word read this cycle lands on DI at the next edge.
   assign push      = en_q;
   assign pop       = OUT_VALID & OUT_READY;
   assign push_last = (addr_q == LastAddr);

   always_comb begin
      data0_d = data0_q;
      data1_d = data1_q;
      idx0_d  = idx0_q;
      idx1_d  = idx1_q;
      last0_d = last0_q;
      last1_d = last1_q;
      count_d = count_q;
      case ({push, pop})
         2'b10: begin
            if (count_q == 2'd0) begin
               data0_d = DI;
               idx0_d  = addr_q;
               last0_d = push_last;
            end else begin
               data1_d = DI;
               idx1_d  = addr_q;
               last1_d = push_last;
            end
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            data0_d = data1_q;
            idx0_d  = idx1_q;
            last0_d = last1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            if (count_q == 2'd1) begin
               data0_d = DI;
               idx0_d  = addr_q;
               last0_d = push_last;
            end else begin
               data0_d = data1_q;
               idx0_d  = idx1_q;
               last0_d = last1_q;
               data1_d = DI;
               idx1_d  = addr_q;
               last1_d = push_last;
            end
         end
         default: ;
      endcase
   end

   // A read is registered only if the buffer is guaranteed room when its word arrives.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      en_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (START) begin
               en_d    = 1'b1;
               addr_d  = '0;
               cnt_d   = (DEPTH > 1) ? ADDR_W'(1) : '0;
               state_d = (DEPTH == 1) ? StDrain : StFetch;
            end
         end
         StFetch: begin
            if (count_d < 2'd2) begin
               en_d   = 1'b1;
               addr_d = cnt_q;
               if (cnt_q == LastAddr) begin
                  state_d = StDrain;
               end else begin
                  cnt_d = cnt_q + ADDR_W'(1);
               end
            end
         end
         StDrain: begin
            if (!en_q && (count_d == 2'd0)) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         en_q    <= 1'b0;
         count_q <= 2'd0;
         data0_q <= '0;
         data1_q <= '0;
         idx0_q  <= '0;
         idx1_q  <= '0;
         last0_q <= 1'b0;
         last1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         en_q    <= en_d;
         count_q <= count_d;
         data0_q <= data0_d;
         data1_q <= data1_d;
         idx0_q  <= idx0_d;
         idx1_q  <= idx1_d;
         last0_q <= last0_d;
         last1_q <= last1_d;
      end
   end

   assign BUSY      = (state_q != StIdle);
   assign DONE      = (state_q == StDone);
   assign ADDR      = addr_q;
   assign EN        = en_q;
   assign WE        = 1'b0;
   assign OUT_VALID = (count_q != 2'd0);
   assign OUT_LAST  = OUT_VALID & last0_q;
   assign OUT_DATA  = data0_q;
   assign OUT_IDX   = idx0_q;

endmodule
